lfsr_rx_deser: RTL
==================

# lfsr_rx_deser

Serial-to-parallel receive stage that sits directly downstream of the LFSR block, consuming its `OUT`/`Valid` bit stream. It reassembles LSB-first serial bits into `LFSR_WD`-bit words, presents each word on a valid/ready output handshake, and compares it against an expected value. It flags truncated frames and overruns, and keeps delivered-word and mismatch counters for the system bench.

## Interface
- `LFSR_WD`, 8: word width in bits, must be ≥ 2.
- `CNT_WD`, 8: width of the word and mismatch counters.

- `CLK`  in  1  clock; all state changes on its rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `Ser_In`  in  1  serial data bit, from LFSR `OUT`.
- `Ser_Valid`  in  1  qualifies `Ser_In`, from LFSR `Valid`.
- `Exp_Data`  in  `LFSR_WD`  expected word, compared against `Par_Out`.
- `Par_Ready`  in  1  consumer accepts the word held on `Par_Out`.
- `Par_Out`  out  `LFSR_WD`  assembled word; bit 0 is the first bit received.
- `Par_Valid`  out  1  `Par_Out` holds an unaccepted word.
- `Match`  out  1  `Par_Valid && (Par_Out == Exp_Data)`, combinational.
- `Frame_Err`  out  1  one-cycle pulse: a partial word was discarded.
- `Overrun`  out  1  sticky: a completed word was dropped.
- `Word_Cnt`  out  `CNT_WD`  accepted words; wraps modulo 2^`CNT_WD`.
- `Mis_Cnt`  out  `CNT_WD`  words accepted while `Match` = 0; saturates at all-ones.

## Operation
- Reset (`RST` = 0, asynchronous) drives every output and internal register to 0:
  - FSM goes to IDLE; shift register, bit counter, `Par_Out`, `Par_Valid`, `Frame_Err`, `Overrun`, `Word_Cnt` and `Mis_Cnt` all clear.
  - Reset mid-frame discards the partial word. A reset while `Par_Valid` = 1 drops the held word; no flag is raised.
- FSM states:
  - IDLE: bit counter = 0. `Ser_Valid` = 1 samples bit 0 into shift position 0, sets the counter to 1 and moves to SHIFT.
  - SHIFT, `Ser_Valid` = 1: bit[cnt] = `Ser_In`, cnt increments. When cnt reaches `LFSR_WD`-1 that edge samples the last bit, the word completes, cnt returns to 0 and the FSM stays in SHIFT.
  - SHIFT, `Ser_Valid` = 0 with cnt ≠ 0: partial word discarded, `Frame_Err` pulses for the next cycle, FSM goes to IDLE.
  - SHIFT, `Ser_Valid` = 0 with cnt = 0: clean frame end, FSM goes to IDLE, no error.
- Word completion with the holding register empty, or freed by `Par_Ready` in the same cycle: the word loads into `Par_Out` and `Par_Valid` is set.
- Word completion while the holding register is full and `Par_Ready` = 0: the new word is dropped, `Par_Out` is unchanged and `Overrun` is set. `Overrun` clears only on reset.
- Handshake: a word is accepted on an edge where `Par_Valid` = 1 and `Par_Ready` = 1.
  - Acceptance increments `Word_Cnt`.
  - It increments `Mis_Cnt` if `Match` = 0 and `Mis_Cnt` is not all-ones.
  - With no simultaneous load, `Par_Valid` falls.
- `Par_Out` is stable while `Par_Valid` = 1 and not yet accepted.
- `Par_Ready` while `Par_Valid` = 0 has no effect.
- `Exp_Data` must be stable while `Par_Valid` = 1.

## Timing
- `Ser_In` and `Ser_Valid` are sampled on the rising edge of `CLK`.
- Latency: `Par_Valid` rises on the same edge that samples the last (bit `LFSR_WD`-1) serial bit. The word is visible in the following cycle.
- Continuous `Ser_Valid` for n·`LFSR_WD` cycles yields n back-to-back words with no bubble. Holding `Par_Ready` = 1 sustains this with no overrun.
- `Frame_Err` asserts the cycle after the edge that sees `Ser_Valid` low mid-word and lasts exactly one cycle.
- Counters update on the acceptance edge.

## Test plan
- Reset check: assert `RST` = 0 asynchronously mid-cycle → all outputs are 0 immediately, before the next edge.
- Single word: drive 8'hA5 LSB first (1,0,1,0,0,1,0,1) with `Ser_Valid` = 1 for 8 cycles, `Exp_Data` = 8'hA5, `Par_Ready` = 0 →
  - `Par_Valid` = 1 and `Par_Out` = 8'hA5 with `Match` = 1, after the 8th edge.
  - Raising `Par_Ready` for one cycle then gives `Word_Cnt` = 1, `Mis_Cnt` = 0, `Par_Valid` = 0.
- Back-to-back with mismatch: stream 8'h3C then 8'hC3 for 16 cycles, `Par_Ready` = 1, `Exp_Data` = 8'h3C →
  - both words are delivered on consecutive word boundaries;
  - `Word_Cnt` = 2, `Mis_Cnt` = 1, `Overrun` = 0.
- Truncated frame: 5 valid bits then `Ser_Valid` = 0 → `Frame_Err` is high for exactly 1 cycle, `Par_Valid` stays 0, and a following full word 8'h0F is received correctly.
- Overrun: stream 8'h11 then 8'h22 with `Par_Ready` = 0 → `Par_Out` stays 8'h11 and `Overrun` = 1 after the 16th edge. Repeating with `Par_Ready` pulsed on the 16th edge gives `Par_Out` = 8'h22 and `Overrun` = 0.
- Reset mid-frame and saturation:
  - `RST` low after 4 bits, then a full word 8'h81 → `Par_Out` = 8'h81 with no `Frame_Err`.
  - With `CNT_WD` = 2, four mismatching accepted words → `Mis_Cnt` saturates at 2'b11 and `Word_Cnt` wraps to 0.

Source files
------------

// File: rtl/lfsr_rx_deser.sv
// LSB-first serial-to-parallel receiver for the LFSR bit stream, with a
// one-word valid/ready holding register, expected-word compare and counters.
module lfsr_rx_deser #(
    parameter int LFSR_WD = 8,
    parameter int CNT_WD  = 8
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               Ser_In,
    input  logic               Ser_Valid,
    input  logic [LFSR_WD-1:0] Exp_Data,
    input  logic               Par_Ready,
    output logic [LFSR_WD-1:0] Par_Out,
    output logic               Par_Valid,
    output logic               Match,
    output logic               Frame_Err,
    output logic               Overrun,
    output logic [CNT_WD-1:0]  Word_Cnt,
    output logic [CNT_WD-1:0]  Mis_Cnt
);

    localparam int BW = $clog2(LFSR_WD);
    localparam logic [BW-1:0] LAST_BIT = BW'(LFSR_WD - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [BW-1:0]       bit_cnt;
    logic [LFSR_WD-1:0]  shreg;
    logic [LFSR_WD-1:0]  word;
    logic                word_done;
    logic                abort;
    logic                accept;
    logic                load;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (Ser_Valid)  state_nxt = SHIFT;
            SHIFT:   if (!Ser_Valid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        word_done = 1'b0;
        abort     = 1'b0;
        if (state == SHIFT) begin
            word_done = Ser_Valid && (bit_cnt == LAST_BIT);
            abort     = !Ser_Valid && (bit_cnt != '0);
        end
    end

    // The last bit is still on Ser_In when the word completes, so splice it in.
    assign word   = {Ser_In, shreg[LFSR_WD-2:0]};
    assign accept = Par_Valid && Par_Ready;
    assign load   = word_done && (!Par_Valid || Par_Ready);
    assign Match  = Par_Valid && (Par_Out == Exp_Data);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (Ser_Valid) begin
            shreg[bit_cnt] <= Ser_In;
            bit_cnt        <= word_done ? '0 : bit_cnt + BW'(1);
        end else begin
            bit_cnt <= '0;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            Par_Out   <= '0;
            Par_Valid <= 1'b0;
            Frame_Err <= 1'b0;
            Overrun   <= 1'b0;
            Word_Cnt  <= '0;
            Mis_Cnt   <= '0;
        end else begin
            Frame_Err <= abort;
            if (load) begin
                Par_Out   <= word;
                Par_Valid <= 1'b1;
            end else if (accept) begin
                Par_Valid <= 1'b0;
            end
            if (word_done && !load) begin
                Overrun <= 1'b1;
            end
            if (accept) begin
                Word_Cnt <= Word_Cnt + CNT_WD'(1);
                if (!Match && (Mis_Cnt != '1)) begin
                    Mis_Cnt <= Mis_Cnt + CNT_WD'(1);
                end
            end
        end
    end

endmodule
